// File: rtl/data_mem_stage.sv
// Memory/writeback stage: multi-cycle loads and stores against an internal word RAM,
// then a single-cycle strobe on the register-file write port.
module data_mem_stage #(
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int RA_W        = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      op,
  input  logic            we,
  input  logic            wem,
  input  logic [31:0]     address,
  input  logic [31:0]     dataout,
  input  logic [RA_W-1:0] rd_idx,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic            err_misalign,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2
  } state_t;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  logic [1:0]      cap_op;
  logic            cap_we;
  logic            cap_wem;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_data;
  logic [RA_W-1:0] cap_rd;
  logic            err_d;
  logic            wb_load;
  logic [31:0]     wb_data;
  logic            mem_we;
  logic [31:0]     mem_rdata;
  logic            accept;
  logic            aligned;
  logic            unused_addr;

  logic [31:0] mem [2**AW];

  // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so upstream must hold its request while we are busy.
  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign aligned   = (address[1:0] == 2'b00);
  assign rf_we     = (state == S_WB);
  assign rf_waddr  = cap_rd;
  assign dbg_state = state;
  assign mem_rdata = mem[cap_idx];

  // Address bits above the RAM window alias silently.
  assign unused_addr = ^address[31:AW+2];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    err_d   = 1'b0;
    wb_load = 1'b0;
    wb_data = rf_wdata;
    mem_we  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_ALU: begin
              if (we) begin
                state_d = S_WB;
                wb_load = 1'b1;
                wb_data = dataout;
              end
            end
            OP_LW, OP_SW: begin
              if (aligned) begin
                state_d = S_ACCESS;
                cnt_d   = CNT_INIT;
              end else begin
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      S_ACCESS: begin
        if (cnt == 4'd0) begin
          state_d = S_IDLE;
          if (cap_op == OP_SW) begin
            mem_we = cap_wem;
          end else if (cap_we) begin
            state_d = S_WB;
            wb_load = 1'b1;
            wb_data = mem_rdata;
          end
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      err_misalign <= 1'b0;
      rf_wdata     <= 32'd0;
      cap_op       <= 2'b11;
      cap_we       <= 1'b0;
      cap_wem      <= 1'b0;
      cap_idx      <= '0;
      cap_data     <= 32'd0;
      cap_rd       <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      err_misalign <= err_d;
      if (wb_load) rf_wdata <= wb_data;
      if (accept) begin
        cap_op   <= op;
        cap_we   <= we;
        cap_wem  <= wem;
        cap_idx  <= address[AW+1:2];
        cap_data <= dataout;
        cap_rd   <= rd_idx;
      end
    end
  end

  // RAM contents survive reset; the write is gated by the reset-cleared state.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cap_idx] <= cap_data;
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: ALU writeback, load/store timing, misalignment,
// address aliasing, reset during an access and back-to-back requests.
module tb_data_mem_stage;

  localparam int AW = 8;
  localparam int W  = 2;
  localparam int RA_W = 5;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      op;
  logic            we;
  logic            wem;
  logic [31:0]     address;
  logic [31:0]     dataout;
  logic [RA_W-1:0] rd_idx;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [31:0]     rf_wdata;
  logic            err_misalign;
  logic [1:0]      dbg_state;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [RA_W-1:0] exp_a_q[$];

  data_mem_stage #(.AW(AW), .WAIT_CYCLES(W), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .we(we), .wem(wem), .address(address), .dataout(dataout),
    .rd_idx(rd_idx), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err_misalign(err_misalign), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_req(input logic [1:0] o, input logic w, input logic wm,
                         input logic [31:0] a, input logic [31:0] d, input logic [RA_W-1:0] r);
    op = o; we = w; wem = wm; address = a; dataout = d; rd_idx = r;
  endtask

  // Present one request for one edge; returns at the negedge after the accept edge.
  task automatic issue(input logic [1:0] o, input logic w, input logic wm,
                       input logic [31:0] a, input logic [31:0] d, input logic [RA_W-1:0] r);
    @(negedge clk);
    set_req(o, w, wm, a, d, r);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: req_ready=%b required 1", name, req_ready);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    issue(2'b10, 1'b0, 1'b1, a, d, '0);
    wait_idle("store");
  endtask

  // Load and return the written-back data (bounded wait for rf_we).
  task automatic do_load(input logic [31:0] a, input logic [RA_W-1:0] r, output logic [31:0] d);
    int k;
    issue(2'b01, 1'b1, 1'b0, a, 32'd0, r);
    k = 0;
    while (rf_we !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (rf_we !== 1'b1) begin
      n_err++;
      $display("FAIL load_timeout: rf_we=%b required 1", rf_we);
    end
    d = rf_wdata;
    wait_idle("load");
  endtask

  task automatic test_reset();
    n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_chk++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rst_rf_we: got %b want 0", rf_we); end
    n_chk++; if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL rst_waddr: got %0d want 0", rf_waddr); end
    n_chk++; if (rf_wdata !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", rf_wdata); end
    n_chk++; if (err_misalign !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_misalign); end
    n_chk++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_alu();
    issue(2'b00, 1'b1, 1'b0, 32'd0, 32'h0000_00A5, 5'd3);
    n_chk++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL alu_we: got %b want 1", rf_we); end
    n_chk++; if (rf_waddr !== 5'd3) begin n_err++; $display("FAIL alu_waddr: got %0d want 3", rf_waddr); end
    n_chk++; if (rf_wdata !== 32'hA5) begin n_err++; $display("FAIL alu_wdata: got %h want a5", rf_wdata); end
    n_chk++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL alu_busy: got %b want 0", req_ready); end
    @(negedge clk);
    n_chk++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL alu_pulse: got %b want 0", rf_we); end
    n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready: got %b want 1", req_ready); end
    n_chk++; if (rf_wdata !== 32'hA5) begin n_err++; $display("FAIL alu_hold: got %h want a5", rf_wdata); end
    // op 00 with we=0 and op 11 are consumed silently
    issue(2'b00, 1'b0, 1'b0, 32'd0, 32'h1234, 5'd9);
    n_chk++; if (rf_we !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL alu_we0: rf_we=%b ready=%b want 0/1", rf_we, req_ready);
    end
    issue(2'b11, 1'b1, 1'b1, 32'h10, 32'h5555, 5'd9);
    n_chk++; if (rf_we !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL nop: rf_we=%b ready=%b want 0/1", rf_we, req_ready);
    end
  endtask

  task automatic test_store_load();
    issue(2'b10, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
    for (int k = 1; k <= W; k++) begin
      n_chk++; if (req_ready !== 1'b0 || rf_we !== 1'b0) begin
        n_err++; $display("FAIL sw_busy_%0d: ready=%b rf_we=%b want 0/0", k, req_ready, rf_we);
      end
      @(negedge clk);
    end
    n_chk++; if (req_ready !== 1'b1 || rf_we !== 1'b0) begin
      n_err++; $display("FAIL sw_done: ready=%b rf_we=%b want 1/0", req_ready, rf_we);
    end
    issue(2'b01, 1'b1, 1'b0, 32'h10, 32'd0, 5'd7);
    for (int k = 1; k <= W; k++) begin
      n_chk++; if (req_ready !== 1'b0 || rf_we !== 1'b0) begin
        n_err++; $display("FAIL lw_busy_%0d: ready=%b rf_we=%b want 0/0", k, req_ready, rf_we);
      end
      @(negedge clk);
    end
    n_chk++; if (rf_we !== 1'b1 || req_ready !== 1'b0) begin
      n_err++; $display("FAIL lw_wb: rf_we=%b ready=%b want 1/0", rf_we, req_ready);
    end
    n_chk++; if (rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data: got %h want deadbeef", rf_wdata); end
    n_chk++; if (rf_waddr !== 5'd7) begin n_err++; $display("FAIL lw_waddr: got %0d want 7", rf_waddr); end
    @(negedge clk);
    n_chk++; if (rf_we !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL lw_end: rf_we=%b ready=%b want 0/1", rf_we, req_ready);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] d;
    issue(2'b01, 1'b1, 1'b0, 32'h12, 32'd0, 5'd9);
    n_chk++; if (err_misalign !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b want 1", err_misalign); end
    n_chk++; if (rf_we !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL mis_side: rf_we=%b ready=%b want 0/1", rf_we, req_ready);
    end
    @(negedge clk);
    n_chk++; if (err_misalign !== 1'b0 || rf_we !== 1'b0) begin
      n_err++; $display("FAIL mis_pulse: err=%b rf_we=%b want 0/0", err_misalign, rf_we);
    end
    // misaligned store must not write either
    issue(2'b10, 1'b0, 1'b1, 32'h11, 32'h0BAD_0BAD, 5'd0);
    n_chk++; if (err_misalign !== 1'b1 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL mis_sw: err=%b ready=%b want 1/1", err_misalign, req_ready);
    end
    do_load(32'h10, 5'd2, d);
    n_chk++; if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL mis_ram: got %h want deadbeef", d); end
  endtask

  task automatic test_alias();
    logic [31:0] d;
    do_store(32'h0000_0400, 32'hCAFE_F00D);
    do_load(32'h0, 5'd1, d);
    n_chk++; if (d !== 32'hCAFE_F00D) begin n_err++; $display("FAIL alias: got %h want cafef00d", d); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] d;
    do_store(32'h20, 32'h1111);
    issue(2'b10, 1'b0, 1'b1, 32'h20, 32'h2222, 5'd0);
    rst = 1'b1;
    #1;
    n_chk++; if (req_ready !== 1'b1 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL rmid_state: ready=%b state=%0d want 1/0", req_ready, dbg_state);
    end
    n_chk++; if (rf_wdata !== 32'd0 || rf_waddr !== 5'd0 || rf_we !== 1'b0) begin
      n_err++; $display("FAIL rmid_out: wdata=%h waddr=%0d rf_we=%b want 0/0/0", rf_wdata, rf_waddr, rf_we);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_load(32'h20, 5'd4, d);
    n_chk++; if (d !== 32'h1111) begin n_err++; $display("FAIL rmid_ram: got %h want 1111", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0]     bb_d[3];
    logic [RA_W-1:0] bb_r[3];
    logic            will_acc;
    logic [31:0]     ed;
    logic [RA_W-1:0] ea;
    int item, pulses, last_acc;
    bb_d = '{32'h11, 32'h22, 32'h33};
    bb_r = '{5'd4, 5'd5, 5'd6};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(bb_d[i]);
      exp_a_q.push_back(bb_r[i]);
    end
    item = 0; pulses = 0; last_acc = -1;
    @(negedge clk);
    set_req(2'b00, 1'b1, 1'b0, 32'd0, bb_d[0], bb_r[0]);
    req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      will_acc = req_valid && req_ready;
      if (will_acc) begin
        if (last_acc >= 0) begin
          n_chk++; if (c - last_acc != 2) begin
            n_err++; $display("FAIL b2b_spacing: got %0d want 2", c - last_acc);
          end
        end
        last_acc = c;
      end
      @(negedge clk);
      if (will_acc) begin
        item++;
        if (item < 3) set_req(2'b00, 1'b1, 1'b0, 32'd0, bb_d[item], bb_r[item]);
        else req_valid = 1'b0;
      end
      if (rf_we === 1'b1) begin
        pulses++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra: rf_wdata=%h with nothing expected", rf_wdata);
        end else begin
          ed = exp_q.pop_front();
          ea = exp_a_q.pop_front();
          if (rf_wdata !== ed || rf_waddr !== ea) begin
            n_err++; $display("FAIL b2b_data: got %h/%0d want %h/%0d", rf_wdata, rf_waddr, ed, ea);
          end
        end
      end
    end
    req_valid = 1'b0;
    n_chk++; if (pulses != 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", pulses); end
    exp_q.delete();
    exp_a_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    set_req(2'b11, 1'b0, 1'b0, 32'd0, 32'd0, '0);
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_alu();
    test_store_load();
    test_misalign();
    test_alias();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_stage.md
Name: data_mem_stage

Overview:
- Memory/writeback stage directly downstream of the execute-stage result selector.
- Consumes the selected result (register write enable, memory write enable, address, data) plus the operation code.
- Performs multi-cycle accesses to an internal word RAM, then drives the single register-file write port.
- Stalls upstream with a valid/ready handshake while an access is in flight.

Parameters:
- AW, 8: log2 of RAM depth in 32-bit words (256 words).
- WAIT_CYCLES, 2: memory access latency in cycles, legal range 1..15.
- RA_W, 5: register destination index width.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Asynchronous, active-high reset.
- req_valid  input  1  Upstream presents a request this cycle.
- req_ready  output  1  Stage can accept a request; transfer occurs when req_valid && req_ready at a clk edge.
- op  input  2  00 ALU writeback, 01 load (lw), 10 store (sw), 11 no-op.
- we  input  1  Register write enable from upstream.
- wem  input  1  Memory write enable from upstream.
- address  input  32  Byte address for load/store.
- dataout  input  32  ALU result (op 00) or store data (op 10).
- rd_idx  input  RA_W  Destination register for op 00/01.
- rf_we  output  1  Register-file write strobe, exactly one cycle.
- rf_waddr  output  RA_W  Register-file write index.
- rf_wdata  output  32  Register-file write data.
- err_misalign  output  1  One-cycle pulse when a load/store address has address[1:0] != 0.

Behaviour:
- Reset (async, immediate): state = IDLE, req_ready = 1, rf_we = 0, rf_waddr = 0, rf_wdata = 0, err_misalign = 0, wait counter = 0. RAM contents are not cleared.
- A request is captured on the accepting edge: op, we, wem, address, dataout, rd_idx.
- States: IDLE, ACCESS, WB.
- IDLE
  - req_ready = 1.
  - On accept with op 00 and we = 1: go to WB with rf_wdata = dataout (1-cycle latency: rf_we high in the cycle after the accept edge).
  - On accept with op 01/10 and address[1:0] = 0: go to ACCESS and load the counter with WAIT_CYCLES-1.
  - On accept with op 01/10 and misaligned address: stay in IDLE and pulse err_misalign next cycle. No RAM access and no register write.
  - On accept with op 11, or op 00 with we = 0: consumed with no effect.
- ACCESS
  - req_ready = 0. The counter decrements each cycle.
  - When the counter = 0:
    - Store (requires wem = 1): RAM[address[AW+1:2]] <= dataout, then go to IDLE.
    - Load (requires we = 1): rf_wdata <= RAM[address[AW+1:2]], then go to WB.
    - Store with wem = 0, or load with we = 0: completes silently and returns to IDLE.
- WB
  - rf_we = 1, rf_waddr = captured rd_idx, req_ready = 0.
  - Next cycle: go to IDLE with rf_we = 0.
  - rf_wdata holds its value until the next writeback.
- Latency from accept edge to rf_we high: op 00 = 1 cycle, load = WAIT_CYCLES+1 cycles. A store completes WAIT_CYCLES cycles after accept.
- Throughput: no pipelining. req_ready returns to 1 in the cycle after WB, or after the store completes.
- Address bits above AW+1 are ignored (aliasing/wrap-around, no error).
- rd_idx = 0 is written normally; the register file handles r0.
- req_valid while req_ready = 0 is ignored. Upstream must hold the request.
- Reset mid-ACCESS: the in-flight store is not performed and no rf_we is issued.

Test Plan:
- op 00, we = 1, dataout = 0x0000_00A5, rd_idx = 3 accepted at edge N -> rf_we = 1, rf_waddr = 3, rf_wdata = 0xA5 during cycle N+1, for one cycle only.
- Store op 10, wem = 1, address = 0x10, dataout = 0xDEADBEEF; then load op 01, we = 1, address = 0x10, rd_idx = 7 -> rf_wdata = 0xDEADBEEF, rf_waddr = 7, rf_we high exactly WAIT_CYCLES+1 cycles after the load accept; req_ready low throughout.
- Load with address = 0x12 -> err_misalign pulses for one cycle, no rf_we, RAM unchanged, req_ready stays 1.
- Store to 0x0000_0400 with AW = 8 (aliases to word 0), then load 0x0 -> returns the stored value.
- Assert rst during ACCESS of a store to 0x20 (pre-loaded with 0x1111) -> outputs return to reset values immediately; a later load of 0x20 returns 0x1111.
- Back-to-back req_valid held high with three op 00 requests -> accepted every 2 cycles, giving three rf_we pulses carrying the correct data in order.
